// File: rtl/cavlc_bit_window.sv
// cavlc_bit_window
// ----------------
// Bitstream front end for the CAVLC decoder. 32-bit big-endian slice-data
// words are appended to an MSB-aligned bit buffer, and the oldest PEEK_W
// unconsumed bits are presented as a look-ahead window. That window is the
// address into the coeff_token ROMs. The active ROM or level/run decoder
// returns a shift amount, and the window advances by that many bits.
// Byte alignment, flush and a consumed-bit counter serve slice-level control.
//
// Ports
//   Clk          rising-edge clock
//   Reset        synchronous, active-high
//   InData       next stream word, first bit in MSB
//   InValid      InData valid
//   InReady      word accepted when InValid & InReady
//   Window       next PEEK_W unconsumed bits, oldest bit in MSB
//   WindowValid  at least PEEK_W bits buffered
//   ShiftEn      consume Shift bits this cycle
//   Shift        bits to consume, 0..PEEK_W
//   AlignEn      discard bits up to the next byte boundary
//   Flush        discard all buffered bits and clear ConsumedBits
//   BitCount     valid bits in the buffer, 0..BUF_W
//   ConsumedBits bits consumed since Reset or Flush (wraps)
//   ShiftErr     one-cycle pulse after an illegal consume request

module cavlc_bit_window #(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64,
    parameter int PEEK_W = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [WORD_W-1:0]            InData,
    input  logic                         InValid,
    output logic                         InReady,
    output logic [PEEK_W-1:0]            Window,
    output logic                         WindowValid,
    input  logic                         ShiftEn,
    input  logic [4:0]                   Shift,
    input  logic                         AlignEn,
    input  logic                         Flush,
    output logic [$clog2(BUF_W+1)-1:0]   BitCount,
    output logic [31:0]                  ConsumedBits,
    output logic                         ShiftErr
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0]  bufQ, bufD;
    logic [CNT_W-1:0]  bitCountQ, bitCountD;
    logic [31:0]       consumedQ, consumedD;
    logic              shiftErrQ, shiftErrD;

    logic              accept;
    logic [2:0]        alignK;
    logic [CNT_W-1:0]  consumeK;
    logic [CNT_W-1:0]  remBits;
    logic              illegal;
    logic [BUF_W-1:0]  wordAligned;

    // Ready looks only at the registered count, so a consume in the same
    // cycle does not open room for a word. A word is accepted only while at
    // least WORD_W free bits remain.
    assign InReady      = (bitCountQ <= CNT_W'(BUF_W - WORD_W));
    assign accept       = InValid & InReady;
    assign Window       = bufQ[BUF_W-1 -: PEEK_W];
    assign WindowValid  = (bitCountQ >= CNT_W'(PEEK_W));
    assign BitCount     = bitCountQ;
    assign ConsumedBits = consumedQ;
    assign ShiftErr     = shiftErrQ;

    // The incoming word is prepared at the MSB. Shifting it right by the
    // number of bits that remain drops it directly behind those bits.
    assign wordAligned  = {InData, {(BUF_W-WORD_W){1'b0}}};

    // Align distance is (8 - ConsumedBits mod 8) mod 8. In 3-bit arithmetic,
    // that equals the negation of the low three bits.
    assign alignK       = 3'd0 - consumedQ[2:0];

    // Consume arbitration and next-state computation. Flush overrides
    // everything. An illegal request freezes the buffer contents but still
    // lets an accepted word append behind the current bits.
    always_comb begin
        consumeK  = '0;
        bufD      = bufQ;
        bitCountD = bitCountQ;
        consumedD = consumedQ;
        shiftErrD = 1'b0;
        remBits   = bitCountQ;

        if (ShiftEn && !AlignEn) begin
            consumeK = CNT_W'(Shift);
        end else if (AlignEn && !ShiftEn) begin
            consumeK = CNT_W'(alignK);
        end

        illegal = (ShiftEn && AlignEn)
               || (ShiftEn && (CNT_W'(Shift) > CNT_W'(PEEK_W)))
               || (consumeK > bitCountQ);

        if (Flush) begin
            bufD      = accept ? wordAligned : '0;
            bitCountD = accept ? CNT_W'(WORD_W) : '0;
            consumedD = '0;
        end else if (illegal) begin
            shiftErrD = 1'b1;
            if (accept) begin
                bufD      = bufQ | (wordAligned >> bitCountQ);
                bitCountD = bitCountQ + CNT_W'(WORD_W);
            end
        end else begin
            remBits   = bitCountQ - consumeK;
            bufD      = bufQ << consumeK;
            if (accept) begin
                bufD = bufD | (wordAligned >> remBits);
            end
            bitCountD = remBits + (accept ? CNT_W'(WORD_W) : CNT_W'(0));
            consumedD = consumedQ + 32'(consumeK);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bufQ      <= '0;
            bitCountQ <= '0;
            consumedQ <= '0;
            shiftErrQ <= 1'b0;
        end else begin
            bufQ      <= bufD;
            bitCountQ <= bitCountD;
            consumedQ <= consumedD;
            shiftErrQ <= shiftErrD;
        end
    end

endmodule

// File: tb/tb_cavlc_bit_window.sv
// tb_cavlc_bit_window
// -------------------
// Directed bench for cavlc_bit_window. Each step drives one cycle of inputs.
// Outputs are compared 1 ns after the clock edge against hand-computed values.

module tb_cavlc_bit_window;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inData = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [15:0] window;
    logic        windowValid;
    logic        shiftEn = 1'b0;
    logic [4:0]  shift = '0;
    logic        alignEn = 1'b0;
    logic        flush = 1'b0;
    logic [6:0]  bitCount;
    logic [31:0] consumedBits;
    logic        shiftErr;

    int testsRun    = 0;
    int testsFailed = 0;

    cavlc_bit_window dut (
        .Clk          (clk),
        .Reset        (reset),
        .InData       (inData),
        .InValid      (inValid),
        .InReady      (inReady),
        .Window       (window),
        .WindowValid  (windowValid),
        .ShiftEn      (shiftEn),
        .Shift        (shift),
        .AlignEn      (alignEn),
        .Flush        (flush),
        .BitCount     (bitCount),
        .ConsumedBits (consumedBits),
        .ShiftErr     (shiftErr)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, wait past the edge, then return to idle.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic sEn, input logic [4:0] sh,
                                 input logic aEn, input logic fl);
        inValid = v;
        inData  = d;
        shiftEn = sEn;
        shift   = sh;
        alignEn = aEn;
        flush   = fl;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inData  = '0;
        shiftEn = 1'b0;
        shift   = '0;
        alignEn = 1'b0;
        flush   = 1'b0;
    endtask

    // Check the full observable state in one call.
    task automatic checkState(input string tag, input logic [15:0] w,
                              input logic [6:0] cnt, input logic [31:0] cons,
                              input logic err, input logic rdy, input logic wv);
        checkOutput({tag, ".Window"},      32'(window),       32'(w));
        checkOutput({tag, ".BitCount"},    32'(bitCount),     32'(cnt));
        checkOutput({tag, ".Consumed"},    consumedBits,      cons);
        checkOutput({tag, ".ShiftErr"},    32'(shiftErr),     32'(err));
        checkOutput({tag, ".InReady"},     32'(inReady),      32'(rdy));
        checkOutput({tag, ".WindowValid"}, 32'(windowValid),  32'(wv));
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkState("reset", 16'h0000, 7'd0, 32'd0, 1'b0, 1'b1, 1'b0);

        // First word and single-bit consumes
        applyStimulus(1, 32'hF000_0000, 0, 5'd0, 0, 0);
        checkState("load1", 16'hF000, 7'd32, 32'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 32'h0, 1, 5'd1, 0, 0);
        checkState("sh1", 16'hE000, 7'd31, 32'd1, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 32'h0, 1, 5'd7, 0, 0);
        checkState("sh7", 16'h0000, 7'd24, 32'd8, 1'b0, 1'b1, 1'b1);

        // Drain to empty
        applyStimulus(0, 32'h0, 1, 5'd16, 0, 0);
        applyStimulus(0, 32'h0, 1, 5'd8, 0, 0);
        checkState("drain", 16'h0000, 7'd0, 32'd32, 1'b0, 1'b1, 1'b0);

        // Fill to full; a word offered at full must be refused
        applyStimulus(1, 32'h1234_5678, 0, 5'd0, 0, 0);
        applyStimulus(1, 32'h9ABC_DEF0, 0, 5'd0, 0, 0);
        checkState("full", 16'h1234, 7'd64, 32'd32, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 32'hDEAD_BEEF, 1, 5'd16, 0, 0);
        checkState("full_sh16", 16'h5678, 7'd48, 32'd48, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 32'h0, 1, 5'd16, 0, 0);
        checkState("sh16b", 16'h9ABC, 7'd32, 32'd64, 1'b0, 1'b1, 1'b1);

        // Consume while appending: 25 old bits, then CAFEBABE
        applyStimulus(1, 32'hCAFE_BABE, 1, 5'd7, 0, 0);
        checkState("sh7_app", 16'h5E6F, 7'd57, 32'd71, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 32'h0, 1, 5'd16, 0, 0);
        checkState("app_sh16", 16'h7865, 7'd41, 32'd87, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 32'h0, 1, 5'd9, 0, 0);
        checkState("app_sh9", 16'hCAFE, 7'd32, 32'd96, 1'b0, 1'b1, 1'b1);

        // Illegal: Shift above window width
        applyStimulus(0, 32'h0, 1, 5'd17, 0, 0);
        checkState("ill_sh17", 16'hCAFE, 7'd32, 32'd96, 1'b1, 1'b1, 1'b1);
        applyStimulus(0, 32'h0, 0, 5'd0, 0, 0);
        checkOutput("ill_sh17.pulse_end", 32'(shiftErr), 32'd0);

        // Illegal: consume beyond available bits (5 left: 11110)
        applyStimulus(0, 32'h0, 1, 5'd16, 0, 0);
        applyStimulus(0, 32'h0, 1, 5'd11, 0, 0);
        checkState("five_left", 16'hF000, 7'd5, 32'd123, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 32'h0, 1, 5'd9, 0, 0);
        checkState("ill_under", 16'hF000, 7'd5, 32'd123, 1'b1, 1'b1, 1'b0);

        // Illegal: ShiftEn and AlignEn together
        applyStimulus(0, 32'h0, 1, 5'd1, 1, 0);
        checkState("ill_both", 16'hF000, 7'd5, 32'd123, 1'b1, 1'b1, 1'b0);

        // Illegal consume still appends an accepted word behind the 5 bits
        applyStimulus(1, 32'h1234_5678, 1, 5'd9, 0, 0);
        checkState("ill_app", 16'hF091, 7'd37, 32'd123, 1'b1, 1'b0, 1'b1);

        // Flush alone, then flush with a word and an illegal shift
        applyStimulus(0, 32'h0, 0, 5'd0, 0, 1);
        checkState("flush", 16'h0000, 7'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1, 32'hA5A5_A5A5, 1, 5'd17, 0, 1);
        checkState("flush_ld", 16'hA5A5, 7'd32, 32'd0, 1'b0, 1'b1, 1'b1);

        // Byte alignment from ConsumedBits = 13
        applyStimulus(0, 32'h0, 1, 5'd13, 0, 0);
        checkState("sh13", 16'hB4B4, 7'd19, 32'd13, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 32'h0, 0, 5'd0, 1, 0);
        checkState("align", 16'hA5A5, 7'd16, 32'd16, 1'b0, 1'b1, 1'b1);
        applyStimulus(0, 32'h0, 0, 5'd0, 1, 0);
        checkState("align0", 16'hA5A5, 7'd16, 32'd16, 1'b0, 1'b1, 1'b1);

        // Reset mid-stream with a word offered
        applyStimulus(1, 32'h5555_AAAA, 1, 5'd3, 0, 0);
        reset   = 1'b1;
        inValid = 1'b1;
        inData  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        checkState("midreset", 16'h0000, 7'd0, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cavlc_bit_window.md
Name: cavlc_bit_window

Overview:
- Bitstream front end for the CAVLC decoder. Takes 32-bit big-endian slice-data words from the input FIFO and holds them in an MSB-aligned bit buffer.
- Presents a 16-bit look-ahead window, which is the Address driven into the coeff_token ROMs (all nC classes, including nC=-2).
- Advances by the NumShift value returned by whichever ROM or level/run decoder is active.
- Also provides byte alignment, flush and a consumed-bit counter for slice-level control.

Parameters:
WORD_W  32  input word width
BUF_W   64  bit buffer width; must be at least 2*WORD_W
PEEK_W  16  look-ahead window width; largest legal shift

Ports:
Clk          input   1        rising-edge clock
Reset        input   1        synchronous, active-high
InData       input   WORD_W   next stream word, first bit in MSB
InValid      input   1        InData valid
InReady      output  1        word accepted when InValid & InReady
Window       output  PEEK_W   next PEEK_W unconsumed bits, oldest bit in MSB
WindowValid  output  1        BitCount >= PEEK_W
ShiftEn      input   1        consume Shift bits this cycle
Shift        input   5        bits to consume, 0..16
AlignEn      input   1        discard bits up to the next byte boundary
Flush        input   1        discard all buffered bits and clear ConsumedBits
BitCount     output  7        valid bits in the buffer, 0..64
ConsumedBits output  32       bits consumed since Reset or Flush; wraps at 2^32
ShiftErr     output  1        one-cycle pulse on an illegal consume request

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-high.
- State registers: Buf[BUF_W-1:0] (MSB-aligned), BitCount and ConsumedBits.
- Window is Buf[BUF_W-1 -: PEEK_W], a combinational decode of the register. It reflects every update one cycle after that update.
- Reset clears Buf, BitCount, ConsumedBits and ShiftErr to 0. InReady is then 1, WindowValid is 0 and Window is 16'h0000.
- InReady = (BitCount <= BUF_W-WORD_W). This is combinational from the register only and never depends on InValid.
- Consume amount K is computed each cycle:
  - ShiftEn alone: K = Shift.
  - AlignEn alone: K = (8 - ConsumedBits[2:0]) mod 8.
  - Neither asserted: K = 0.
- A request is illegal when any of these hold; ShiftErr pulses on the next cycle and Buf, BitCount and ConsumedBits do not change from the consume:
  - ShiftEn and AlignEn are both asserted.
  - Shift > PEEK_W.
  - K > BitCount.
- Legal update, all in one cycle:
  - Buf shifts left by K, zero-filled.
  - If a word is accepted the same cycle, it is placed at bit position BUF_W-1-(BitCount-K) downward.
  - BitCount' = BitCount - K + (accept ? WORD_W : 0).
  - ConsumedBits' = ConsumedBits + K, modulo 2^32.
- An illegal consume does not block a word accepted that cycle; the word is appended at the unshifted position.
- K = 0 is legal and leaves the buffer unchanged. A ROM miss returns NumShift 0, and detecting that is the caller's job.
- Flush has highest priority:
  - Clears Buf, BitCount and ConsumedBits.
  - Ignores ShiftEn and AlignEn, with no ShiftErr.
  - A word accepted in the flush cycle is loaded at the MSB, giving BitCount = 32.
- Reset mid-operation behaves exactly as at power-up. Any in-flight handshake is dropped.
- Latency:
  - Accepted word to Window: 1 cycle.
  - Consume to new Window: 1 cycle.
  - Back-to-back consumes every cycle are supported while BitCount stays at or above each K.
- Throughput: with at most 16 bits consumed per cycle and 32 loaded per accepted word, the buffer never underflows provided InValid is held high.
- Buffer full: BitCount > 32 forces InReady = 0. This holds even in a cycle that consumes bits; there is no look-ahead ready.

Test Plan:
- Reset, then InData=32'hF000_0000 with InValid=1 -> one cycle later Window=16'hF000, BitCount=32, WindowValid=1, InReady=1.
- From that state, ShiftEn with Shift=1 -> Window=16'hE000, BitCount=31, ConsumedBits=1. Then Shift=7 -> Window=16'h0000, BitCount=24, ConsumedBits=8.
- Load 32'h1234_5678 and 32'h9ABC_DEF0 -> BitCount=64 and InReady=0. Shift=16 -> BitCount=48, InReady=0. Shift=16 -> BitCount=32, InReady=1, Window=16'h9ABC.
- BitCount=32, consume Shift=7 while a word is accepted -> BitCount=57, and the appended word's MSB sits directly after the remaining 25 bits. Check Window across the next two consumes.
- Illegal-request sweep:
  - Shift=17 -> ShiftErr pulse, state unchanged.
  - BitCount=5 with Shift=9 -> ShiftErr, state unchanged.
  - ShiftEn and AlignEn together -> ShiftErr, state unchanged.
- ConsumedBits=13, AlignEn -> 3 bits dropped, ConsumedBits=16. Repeat AlignEn -> K=0, no change.
- Flush together with InValid=1 -> BitCount=32, ConsumedBits=0, no ShiftErr.
- Assert Reset mid-stream -> all outputs return to their reset values.
